trd_ctrl_unit: RTL
==================

Name: trd_ctrl_unit

Overview:
- Consumer of the thread-control requests that the execute stage registers into the mem stage: trd_ctrl_mem, obj_trd_mem, new_pc_mem, new_data_mem.
- Owns the run state of all hardware threads: spawn, kill, exit and join.
- Drives the fetch-side PC load port, the register-file initialisation write port and per-thread pipeline flush masks.
- Sits beside the mem stage; one request is accepted per cycle.

Parameters:
NUM_TRD, 8, number of hardware threads (thread id width = $clog2(NUM_TRD), 3 at default)
RESET_PC, 32'h0, PC loaded into thread 0 when reset is released
INIT_REG, 5'd1, destination register in the spawned thread that receives new_data_mem

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
trd_ctrl_mem  in  3  op code: 0 NOP, 1 SPAWN, 2 KILL, 3 EXIT, 4 JOIN, 5-7 reserved (treated as NOP and raise err_tc)
trd_mem  in  3  issuing thread
obj_trd_mem  in  3  target thread
pc_mem  in  32  PC of the issuing instruction
new_pc_mem  in  32  start PC for SPAWN
new_data_mem  in  32  argument written to INIT_REG of the spawned thread
init_gnt  in  1  register-file arbiter accepts the init write this cycle
trd_active  out  NUM_TRD  fetch-eligible thread mask
pc_ld_en  out  1  load the fetch PC of pc_ld_trd
pc_ld_trd  out  3  thread whose PC is loaded
pc_ld_pc  out  32  PC value to load
init_wr_en  out  1  init-write request (valid)
init_trd  out  3  thread targeted by the init write
init_reg  out  5  register targeted by the init write (always INIT_REG)
init_data  out  32  init-write data
kill_mask  out  NUM_TRD  one-cycle pulse; pipeline flushes all in-flight instructions of the marked threads
stall_tc  out  1  combinational; mem stage must hold its request stable while high
err_tc  out  1  one-cycle pulse on an illegal request

Behaviour:
- Per-thread state: FREE, RUN, JOIN_WAIT, RESUME. Each thread also keeps a join target (3 bits) and a resume PC (32 bits).
- Reset values:
  - thread 0 in RUN; all other threads FREE.
  - trd_active = 1, kill_mask = 0, err_tc = 0, init_wr_en = 0.
  - On the first cycle after rst deasserts: pc_ld_en = 1, pc_ld_trd = 0, pc_ld_pc = RESET_PC, for exactly one cycle.
- All outputs except stall_tc are registered; each request takes effect one cycle after it is accepted.
- A request is accepted when trd_ctrl_mem != 0 and stall_tc = 0.
- SPAWN, target FREE:
  - target goes to RUN.
  - pc_ld (target, new_pc_mem) is issued.
  - init write (target, INIT_REG, new_data_mem) is issued.
- SPAWN, target not FREE: err_tc pulses; no state change.
- KILL, target RUN or JOIN_WAIT:
  - target goes to FREE.
  - kill_mask bit of the target pulses.
  - KILL of a FREE target is a no-op.
  - KILL of the issuing thread itself behaves as EXIT.
- EXIT: issuing thread goes to FREE; its kill_mask bit pulses.
- JOIN, target not FREE:
  - issuing thread goes to JOIN_WAIT; join target = obj_trd_mem; resume PC = pc_mem + 4.
  - issuing thread's kill_mask bit pulses.
- JOIN, target FREE: no-op; the thread continues.
- When any thread goes to FREE, every JOIN_WAIT thread whose join target is that thread moves to RESUME.
- Resume service:
  - One RESUME thread is serviced per cycle, lowest index first (tc_prio_enc).
  - Servicing issues pc_ld (thread, resume PC) and moves the thread to RUN.
- trd_active bit = 1 exactly when the thread is in RUN.
- init_wr_en holds until init_gnt. Data and target stay stable while waiting.
- stall_tc = 1 when a request is present and any of these hold:
  - a thread is in RESUME (pc_ld port busy);
  - init_wr_en = 1 and init_gnt = 0, and the request is a SPAWN;
  - the first post-reset cycle.
- Only one pc_ld is issued per cycle.
- rst asserted mid-operation: all state returns to reset values immediately; a pending init write is dropped.

Optional Feature:
- Macro: TC_STAT_EN.
- Defined:
  - adds outputs spawn_cnt[15:0], kill_cnt[15:0], join_cyc_cnt[31:0], all reset to 0.
  - spawn_cnt increments on each successful SPAWN; kill_cnt on each KILL or EXIT that frees a thread.
  - join_cyc_cnt increments once per cycle for each thread in JOIN_WAIT.
  - All three saturate at all-ones.
- Undefined: these ports and their logic are absent; everything else is identical.

Decomposition:
- tc_pkg:
  - trd_op_e enum (NOP, SPAWN, KILL, EXIT, JOIN);
  - trd_state_e enum (FREE, RUN, JOIN_WAIT, RESUME);
  - TRD_W = 3; NUM_TRD default.
- Sub-module tc_prio_enc: NUM_TRD-bit request vector in; lowest-index one-hot grant and its index out. Used for resume selection.

Test Plan:
- Reset release -> thread 0 in RUN; trd_active = 8'h01; one-cycle pc_ld with (0, RESET_PC).
- SPAWN obj = 3, new_pc = 32'h100, data = 32'hABCD, init_gnt held 0 for 2 cycles:
  - pc_ld (3, 32'h100); trd_active = 8'h09;
  - init_wr_en held for 3 cycles with data 32'hABCD;
  - a second SPAWN issued in that window sees stall_tc = 1.
- SPAWN obj = 3 while thread 3 is in RUN -> err_tc pulses for one cycle; no pc_ld; state unchanged.
- Thread 0 issues JOIN obj = 3 with pc_mem = 32'h40:
  - kill_mask = 8'h01; trd_active = 8'h08.
  - Thread 3 then issues EXIT -> kill_mask = 8'h08; next cycle pc_ld (0, 32'h44); trd_active = 8'h01.
- Threads 1 and 2 both JOIN on thread 5; thread 5 is then KILLed:
  - pc_ld for thread 1, then thread 2, on consecutive cycles.
  - A SPAWN issued during those cycles sees stall_tc = 1 until both resumes are done.
- rst asserted while an init write is pending -> all outputs return to reset values; the init write never completes.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and constants for the thread-control unit.
package tc_pkg;

    localparam int TRD_W       = 3;
    localparam int NUM_TRD_DEF = 8;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_SPAWN = 3'd1,
        OP_KILL  = 3'd2,
        OP_EXIT  = 3'd3,
        OP_JOIN  = 3'd4
    } trd_op_e;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_JOIN_WAIT = 2'd2,
        ST_RESUME    = 2'd3
    } trd_state_e;

endpackage

// File: rtl/tc_prio_enc.sv
// Lowest-index-first priority encoder: one-hot grant plus its binary index.
module tc_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    // Scan from the top down so the lowest set request is the last one written.
    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = ($clog2(N))'(i);
            end
        end
    end

endmodule

// File: rtl/trd_ctrl_unit.sv
// Thread-control unit: owns per-thread run state (spawn/kill/exit/join),
// drives fetch PC loads, register-file init writes and flush masks.
// Optional statistics counters are built when TC_STAT_EN is defined.
module trd_ctrl_unit
    import tc_pkg::*;
#(
    parameter int          NUM_TRD  = NUM_TRD_DEF,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [4:0]  INIT_REG = 5'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         trd_ctrl_mem,
    input  logic [TRD_W-1:0]   trd_mem,
    input  logic [TRD_W-1:0]   obj_trd_mem,
    input  logic [31:0]        pc_mem,
    input  logic [31:0]        new_pc_mem,
    input  logic [31:0]        new_data_mem,
    input  logic               init_gnt,
    output logic [NUM_TRD-1:0] trd_active,
    output logic               pc_ld_en,
    output logic [TRD_W-1:0]   pc_ld_trd,
    output logic [31:0]        pc_ld_pc,
    output logic               init_wr_en,
    output logic [TRD_W-1:0]   init_trd,
    output logic [4:0]         init_reg,
    output logic [31:0]        init_data,
    output logic [NUM_TRD-1:0] kill_mask,
    output logic               stall_tc,
    output logic               err_tc
`ifdef TC_STAT_EN
    ,
    output logic [15:0]        spawn_cnt,
    output logic [15:0]        kill_cnt,
    output logic [31:0]        join_cyc_cnt
`endif
);

    trd_state_e [NUM_TRD-1:0]            state_q, state_d;
    logic       [NUM_TRD-1:0][TRD_W-1:0] join_tgt_q, join_tgt_d;
    logic       [NUM_TRD-1:0][31:0]      resume_pc_q, resume_pc_d;

    logic               first_q;
    logic [NUM_TRD-1:0] active_d, kill_d;
    logic               err_d, pc_ld_en_d, init_wr_en_d;
    logic [TRD_W-1:0]   pc_ld_trd_d, init_trd_d;
    logic [31:0]        pc_ld_pc_d, init_data_d;
    logic [NUM_TRD-1:0] resume_vec, resume_gnt;
    logic [TRD_W-1:0]   resume_idx;
    logic               resume_any, req_vld, accept, spawn_ok, free_ok;

    // Collect threads waiting for a PC-load slot.
    always_comb begin
        for (int i = 0; i < NUM_TRD; i++) resume_vec[i] = (state_q[i] == ST_RESUME);
    end

    tc_prio_enc #(.N(NUM_TRD)) u_resume_enc (
        .req (resume_vec),
        .gnt (resume_gnt),
        .idx (resume_idx)
    );

    assign resume_any = |resume_gnt;
    assign req_vld    = (trd_ctrl_mem != OP_NOP);
    // A pending resume owns the PC-load port, so requests wait behind it.
    assign stall_tc   = req_vld && (resume_any || first_q ||
                        (init_wr_en && !init_gnt && trd_ctrl_mem == OP_SPAWN));
    assign accept     = req_vld && !stall_tc;
    assign init_reg   = INIT_REG;

    // Next-state: resume service, request decode, then join wake-up.
    always_comb begin
        logic [NUM_TRD-1:0] freed;
        logic               do_free;
        logic [TRD_W-1:0]   victim;
        state_d      = state_q;
        join_tgt_d   = join_tgt_q;
        resume_pc_d  = resume_pc_q;
        kill_d       = '0;
        err_d        = 1'b0;
        pc_ld_en_d   = 1'b0;
        pc_ld_trd_d  = pc_ld_trd;
        pc_ld_pc_d   = pc_ld_pc;
        init_wr_en_d = init_wr_en && !init_gnt;
        init_trd_d   = init_trd;
        init_data_d  = init_data;
        spawn_ok     = 1'b0;
        free_ok      = 1'b0;
        freed        = '0;
        do_free      = 1'b0;
        victim       = trd_mem;

        if (resume_any) begin
            pc_ld_en_d          = 1'b1;
            pc_ld_trd_d         = resume_idx;
            pc_ld_pc_d          = resume_pc_q[resume_idx];
            state_d[resume_idx] = ST_RUN;
        end

        if (accept) begin
            case (trd_ctrl_mem)
                OP_SPAWN: begin
                    if (state_q[obj_trd_mem] == ST_FREE) begin
                        state_d[obj_trd_mem] = ST_RUN;
                        pc_ld_en_d   = 1'b1;
                        pc_ld_trd_d  = obj_trd_mem;
                        pc_ld_pc_d   = new_pc_mem;
                        init_wr_en_d = 1'b1;
                        init_trd_d   = obj_trd_mem;
                        init_data_d  = new_data_mem;
                        spawn_ok     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_KILL: begin
                    // Self-kill is an exit; the issuer is necessarily running.
                    victim  = obj_trd_mem;
                    do_free = (obj_trd_mem == trd_mem) ||
                              (state_q[obj_trd_mem] == ST_RUN) ||
                              (state_q[obj_trd_mem] == ST_JOIN_WAIT);
                end
                OP_EXIT: begin
                    victim  = trd_mem;
                    do_free = 1'b1;
                end
                OP_JOIN: begin
                    if (state_q[obj_trd_mem] != ST_FREE) begin
                        state_d[trd_mem]     = ST_JOIN_WAIT;
                        join_tgt_d[trd_mem]  = obj_trd_mem;
                        resume_pc_d[trd_mem] = pc_mem + 32'd4;
                        kill_d[trd_mem]      = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end

        if (do_free) begin
            state_d[victim] = ST_FREE;
            kill_d[victim]  = 1'b1;
            freed[victim]   = 1'b1;
            free_ok         = 1'b1;
        end

        for (int i = 0; i < NUM_TRD; i++) begin
            if (state_d[i] == ST_JOIN_WAIT && freed[join_tgt_d[i]]) state_d[i] = ST_RESUME;
            active_d[i] = (state_d[i] == ST_RUN);
        end
    end

    // State and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TRD; i++) state_q[i] <= (i == 0) ? ST_RUN : ST_FREE;
            // NOTE: join targets and resume PCs are only read after being written, but are
            // small enough that a full reset keeps simulation free of X.
            join_tgt_q  <= '0;
            resume_pc_q <= '0;
            first_q     <= 1'b1;
            trd_active  <= NUM_TRD'(1);
            kill_mask   <= '0;
            err_tc      <= 1'b0;
            pc_ld_en    <= 1'b1;
            pc_ld_trd   <= '0;
            pc_ld_pc    <= RESET_PC;
            init_wr_en  <= 1'b0;
            init_trd    <= '0;
            init_data   <= '0;
        end else begin
            state_q     <= state_d;
            join_tgt_q  <= join_tgt_d;
            resume_pc_q <= resume_pc_d;
            first_q     <= 1'b0;
            trd_active  <= active_d;
            kill_mask   <= kill_d;
            err_tc      <= err_d;
            pc_ld_en    <= pc_ld_en_d;
            pc_ld_trd   <= pc_ld_trd_d;
            pc_ld_pc    <= pc_ld_pc_d;
            init_wr_en  <= init_wr_en_d;
            init_trd    <= init_trd_d;
            init_data   <= init_data_d;
        end
    end

`ifdef TC_STAT_EN
    logic [TRD_W:0] jw_cnt;
    logic [32:0]    join_sum;

    // Count waiting threads this cycle and form the saturating join-cycle sum.
    always_comb begin
        jw_cnt = '0;
        for (int i = 0; i < NUM_TRD; i++)
            jw_cnt = jw_cnt + (TRD_W + 1)'(state_q[i] == ST_JOIN_WAIT);
        join_sum = {1'b0, join_cyc_cnt} + 33'(jw_cnt);
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spawn_cnt    <= '0;
            kill_cnt     <= '0;
            join_cyc_cnt <= '0;
        end else begin
            if (spawn_ok && spawn_cnt != 16'hFFFF) spawn_cnt <= spawn_cnt + 16'd1;
            if (free_ok && kill_cnt != 16'hFFFF)   kill_cnt  <= kill_cnt + 16'd1;
            join_cyc_cnt <= join_sum[32] ? 32'hFFFF_FFFF : join_sum[31:0];
        end
    end
`endif

endmodule
